frame_forward_arbiter: RTL

FRAME_FORWARD_ARBITER -- requirements
Module: frame_forward_arbiter

---
 rtl/frame_forward_arbiter.sv | 134 +++++++++++++
 1 files changed

// File: rtl/frame_forward_arbiter.sv
// Round-robin frame arbiter: grants one ingress port per frame, floods its bytes to all
// other egress ports, and inserts a fixed idle gap between frames; stalled frames are aborted.
module frame_forward_arbiter #(
  parameter int NUMBER_OF_PORTS = 2,
  parameter int GAP_CYCLES      = 12,
  parameter int TIMEOUT_CYCLES  = 64,
  localparam int GW = (NUMBER_OF_PORTS > 1) ? $clog2(NUMBER_OF_PORTS) : 1
) (
  input  logic                            clock,
  input  logic                            reset_n,
  input  logic [NUMBER_OF_PORTS-1:0][8:0] port_receive_data,
  input  logic [NUMBER_OF_PORTS-1:0]      port_receive_data_valid,
  output logic [NUMBER_OF_PORTS-1:0]      port_receive_data_ready,
  output logic [8:0]                      port_transmit_data,
  output logic [NUMBER_OF_PORTS-1:0]      port_transmit_data_valid,
  output logic [GW-1:0]                   grant_port,
  output logic                            busy,
  output logic [15:0]                     forwarded_frame_count,
  output logic [15:0]                     aborted_frame_count,
  output logic [1:0]                      fsm_state
);

  // Handshake: a byte moves when ready[g] and valid[g] are both high at a rising edge;
  // ready is held high for the whole frame and only ever on the granted port.
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_FORWARD = 2'd1,
    ST_GAP     = 2'd2
  } state_t;

  state_t                     state;
  logic [GW-1:0]              last_grant;
  logic [15:0]                stall_cnt;
  logic [7:0]                 gap_cnt;

  logic                       found;
  logic [GW-1:0]              winner;
  logic [GW-1:0]              cand;
  logic [NUMBER_OF_PORTS-1:0] grant_onehot;
  logic [NUMBER_OF_PORTS-1:0] flood_mask;
  logic                       accept;
  logic [8:0]                 rx_byte;

  // Search starts one past the previous winner and wraps around all ports.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    cand   = last_grant;
    for (int i = 0; i < NUMBER_OF_PORTS; i++) begin
      cand = (cand == GW'(NUMBER_OF_PORTS - 1)) ? '0 : cand + 1'b1;
      if (!found && port_receive_data_valid[cand]) begin
        found  = 1'b1;
        winner = cand;
      end
    end
  end

  always_comb begin
    grant_onehot         = '0;
    grant_onehot[winner] = 1'b1;
    flood_mask             = '1;
    flood_mask[grant_port] = 1'b0;
  end

  // Masking with ready keeps non-granted (possibly X) valids out of the accept path.
  assign accept  = |(port_receive_data_ready & port_receive_data_valid);
  assign rx_byte = port_receive_data[grant_port];

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state                    <= ST_IDLE;
      port_receive_data_ready  <= '0;
      port_transmit_data_valid <= '0;
      port_transmit_data       <= '0;
      grant_port               <= '0;
      last_grant               <= GW'(NUMBER_OF_PORTS - 1);
      stall_cnt                <= '0;
      gap_cnt                  <= '0;
      forwarded_frame_count    <= '0;
      aborted_frame_count      <= '0;
    end else begin
      port_transmit_data_valid <= '0;
      case (state)
        ST_IDLE: begin
          port_receive_data_ready <= '0;
          port_transmit_data      <= '0;
          stall_cnt               <= '0;
          gap_cnt                 <= '0;
          if (found) begin
            grant_port              <= winner;
            last_grant              <= winner;
            port_receive_data_ready <= grant_onehot;
            state                   <= ST_FORWARD;
          end
        end
        ST_FORWARD: begin
          if (accept) begin
            port_transmit_data       <= rx_byte;
            port_transmit_data_valid <= flood_mask;
            stall_cnt                <= '0;
            if (rx_byte[8]) begin
              port_receive_data_ready <= '0;
              forwarded_frame_count   <= forwarded_frame_count + 16'd1;
              gap_cnt                 <= '0;
              state                   <= ST_GAP;
            end
          end else if (stall_cnt == 16'(TIMEOUT_CYCLES - 1)) begin
            port_receive_data_ready <= '0;
            aborted_frame_count     <= aborted_frame_count + 16'd1;
            stall_cnt               <= '0;
            gap_cnt                 <= '0;
            state                   <= ST_GAP;
          end else begin
            stall_cnt <= stall_cnt + 16'd1;
          end
        end
        ST_GAP: begin
          if (gap_cnt == 8'(GAP_CYCLES - 1)) begin
            gap_cnt            <= '0;
            port_transmit_data <= '0;
            state              <= ST_IDLE;
          end else begin
            gap_cnt <= gap_cnt + 8'd1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign busy      = (state != ST_IDLE);
  assign fsm_state = state;

endmodule
